// File: rtl/rom_uart_streamer.sv
// rom_uart_streamer: walks the message ROM from address 0 and sends each byte
// on tx as an 8N1 UART frame. A frame is one LOAD cycle, then the start bit,
// eight data bits (LSB first) and the stop bit. tx, busy, done, rom_addr and
// char_idx are all registered.
//
// state   | meaning
// --------+----------------------------------------------------------------
// S_IDLE  | line idle (tx=1), address and index held at 0, waiting for start
// S_LOAD  | one cycle: capture rom_data for the registered rom_addr
// S_START | start bit, tx=0 for CLKS_PER_BIT cycles
// S_DATA  | 8 data bits LSB first, shift register moves right after each bit
// S_STOP  | stop bit, tx=1; then the next character, or FIN after the last
// S_FIN   | one cycle: done=1, busy=0; address and index return to 0
module rom_uart_streamer #(
  parameter int MSG_LEN      = 11,
  parameter int CLKS_PER_BIT = 16,
  parameter int ADDR_W       = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [7:0]        rom_data,
  output logic              tx,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] char_idx
);

  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(MSG_LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_START,
    S_DATA,
    S_STOP,
    S_FIN
  } state_e;

  state_e              state_q, state_d;
  logic [BAUD_W-1:0]   baud_q, baud_d;
  logic [2:0]          bit_q, bit_d;
  logic [7:0]          shift_q, shift_d;
  logic [ADDR_W-1:0]   rom_addr_q, rom_addr_d;
  logic [ADDR_W-1:0]   char_idx_q, char_idx_d;
  logic                tx_q, tx_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                baud_end;

  assign baud_end = (baud_q == BAUD_LAST);

  // State register and registered outputs; reset aborts a frame immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      baud_q     <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      rom_addr_q <= '0;
      char_idx_q <= '0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      baud_q     <= baud_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      rom_addr_q <= rom_addr_d;
      char_idx_q <= char_idx_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  // Next-state, counter and output decode. Outputs are decoded from the next
  // state so that the registered versions line up with the state they describe.
  always_comb begin
    state_d    = state_q;
    baud_d     = baud_q;
    bit_d      = bit_q;
    shift_d    = shift_q;
    rom_addr_d = rom_addr_q;
    char_idx_d = char_idx_q;

    unique case (state_q)
      S_IDLE: begin
        rom_addr_d = '0;
        char_idx_d = '0;
        baud_d     = '0;
        bit_d      = '0;
        if (start) state_d = S_LOAD;
      end
      S_LOAD: begin
        shift_d = rom_data;
        baud_d  = '0;
        state_d = S_START;
      end
      S_START: begin
        if (baud_end) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = S_DATA;
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      S_DATA: begin
        if (baud_end) begin
          baud_d  = '0;
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_q == 3'd7) begin
            bit_d   = '0;
            state_d = S_STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      S_STOP: begin
        if (baud_end) begin
          baud_d = '0;
          if (char_idx_q == LAST_IDX) begin
            state_d = S_FIN;
          end else begin
            char_idx_d = char_idx_q + ADDR_W'(1);
            rom_addr_d = rom_addr_q + ADDR_W'(1);
            state_d    = S_LOAD;
          end
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      S_FIN: begin
        rom_addr_d = '0;
        char_idx_d = '0;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    unique case (state_d)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase

    busy_d = (state_d == S_LOAD) || (state_d == S_START) ||
             (state_d == S_DATA) || (state_d == S_STOP);
    done_d = (state_d == S_FIN);
  end

  assign rom_addr = rom_addr_q;
  assign char_idx = char_idx_q;
  assign tx       = tx_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_rom_uart_streamer.sv
// Testbench for rom_uart_streamer: an 11-character instance and a 1-character
// instance share one clock, reset and a behavioural ROM. Expected tx/busy/
// address behaviour comes from a frame-arithmetic model; received bytes come
// from an independent mid-bit UART decoder.
module tb_rom_uart_streamer;

  localparam int CPB   = 16;
  localparam int FRAME = 1 + 10 * CPB;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       start0 = 1'b0, start1 = 1'b0;
  logic [3:0] addr0, addr1, idx0, idx1;
  logic [7:0] data0, data1;
  logic       tx0, tx1, busy0, busy1, done0, done1;

  logic [7:0] rom [16];
  logic       glitch = 1'b0;
  logic [7:0] junk = 8'h00;

  assign data0 = glitch ? junk : rom[addr0];
  assign data1 = rom[addr1];

  rom_uart_streamer #(.MSG_LEN(11), .CLKS_PER_BIT(CPB), .ADDR_W(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start0), .rom_addr(addr0), .rom_data(data0),
    .tx(tx0), .busy(busy0), .done(done0), .char_idx(idx0));

  rom_uart_streamer #(.MSG_LEN(1), .CLKS_PER_BIT(CPB), .ADDR_W(4)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .rom_addr(addr1), .rom_data(data1),
    .tx(tx1), .busy(busy1), .done(done1), .char_idx(idx1));

  bit   sel = 1'b0;
  logic tx_s, busy_s, done_s;
  logic [3:0] addr_s, idx_s;
  assign tx_s   = sel ? tx1   : tx0;
  assign busy_s = sel ? busy1 : busy0;
  assign done_s = sel ? done1 : done0;
  assign addr_s = sel ? addr1 : addr0;
  assign idx_s  = sel ? idx1  : idx0;

  int errors = 0;
  int checks = 0;

  logic cap[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic load_message();
    logic [7:0] msg [11];
    msg = '{8'h45, 8'h4E, 8'h47, 8'h49, 8'h4E, 8'h45, 8'h45, 8'h52, 8'h49, 8'h4E, 8'h47};
    for (int i = 0; i < 16; i++) rom[i] = (i < 11) ? msg[i] : 8'h2E;
  endtask

  // Reference: tx level in cycle k, where cycle 1 is the LOAD of character 0.
  function automatic logic exp_tx(input int k, input int len);
    int c, pos;
    logic [7:0] b;
    if (k < 1 || k > len * FRAME) return 1'b1;
    c   = (k - 1) / FRAME;
    pos = (k - 1) % FRAME;
    b   = rom[c];
    if (pos == 0)        return 1'b1;
    if (pos <= CPB)      return 1'b0;
    if (pos <= 9 * CPB)  return b[(pos - CPB - 1) / CPB];
    return 1'b1;
  endfunction

  // Independent UART receiver over the captured per-cycle tx samples.
  task automatic decode(output logic [7:0] bytes[$]);
    int i;
    logic [7:0] b;
    bytes.delete();
    i = 0;
    while (i + 10 * CPB < cap.size()) begin
      if (cap[i] == 1'b0) begin
        for (int j = 0; j < 8; j++) b[j] = cap[i + CPB / 2 + CPB * (j + 1)];
        bytes.push_back(b);
        i = i + 9 * CPB + CPB / 2;
      end else begin
        i++;
      end
    end
  endtask

  // Send one message on the selected instance and check it cycle by cycle.
  task automatic send_msg(input bit s, input int len, input int n_spam, input bit gl,
                          input int abort_at, input int exp_lat, input string tag);
    int spam_k[$];
    int first_done, ndone, tx_bad, busy_bad, addr_bad, exp_a, dec_bad;
    logic [7:0] dec[$];
    first_done = -1; ndone = 0; tx_bad = 0; busy_bad = 0; addr_bad = 0;
    for (int i = 0; i < n_spam; i++) spam_k.push_back(int'($urandom_range(2, len * FRAME - 20)));
    cap.delete();
    sel = s;
    @(negedge clk);
    glitch = 1'b0;
    if (s) start1 = 1'b1; else start0 = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= len * FRAME + 40; k++) begin
      @(negedge clk);
      start0 = 1'b0;
      start1 = 1'b0;
      foreach (spam_k[i]) if (spam_k[i] == k) begin
        if (s) start1 = 1'b1; else start0 = 1'b1;
      end
      glitch = gl && ((k - 1) % FRAME != 0) && (k <= len * FRAME);
      junk   = 8'($urandom);
      if (abort_at == k) begin
        rst_n = 1'b0;
        #1;
        check({tag, "_rst_tx"}, 32'(tx_s), 32'd1);
        check({tag, "_rst_busy"}, 32'(busy_s), 32'd0);
        check({tag, "_rst_addr"}, 32'(addr_s), 32'd0);
        check({tag, "_no_done"}, 32'(ndone + int'(done_s)), 32'd0);
        @(negedge clk);
        rst_n  = 1'b1;
        glitch = 1'b0;
        return;
      end
      cap.push_back(tx_s);
      if (tx_s !== exp_tx(k, len)) tx_bad++;
      if (busy_s !== (k <= len * FRAME)) busy_bad++;
      if (done_s === 1'b1) begin
        ndone++;
        if (first_done < 0) first_done = k;
      end
      if (k != len * FRAME + 1) begin
        exp_a = (k <= len * FRAME) ? (k - 1) / FRAME : 0;
        if (addr_s !== 4'(exp_a) || idx_s !== 4'(exp_a)) addr_bad++;
      end
    end
    glitch = 1'b0;
    check({tag, "_tx_stream"}, 32'(tx_bad), 32'd0);
    check({tag, "_busy"}, 32'(busy_bad), 32'd0);
    check({tag, "_addr_idx"}, 32'(addr_bad), 32'd0);
    check({tag, "_done_count"}, 32'(ndone), 32'd1);
    check({tag, "_done_latency"}, 32'(first_done - 1), 32'(exp_lat));
    decode(dec);
    dec_bad = (dec.size() == len) ? 0 : 100;
    foreach (dec[i]) if (i < len && dec[i] !== rom[i]) dec_bad++;
    check({tag, "_decode"}, 32'(dec_bad), 32'd0);
  endtask

  typedef struct {
    int n_spam;
    bit glitch;
    bit rand_rom;
    int pre_gap;
    int exp_len;
    int exp_lat;
  } vec_t;

  initial begin
    vec_t vecs[4];
    logic t5_bits[10];
    int   t5_bad, done_cnt, gap, seen_busy;
    int   dk[$];

    vecs[0] = '{n_spam: 0, glitch: 1'b0, rand_rom: 1'b0, pre_gap: 2, exp_len: 11, exp_lat: 1771};
    vecs[1] = '{n_spam: 5, glitch: 1'b0, rand_rom: 1'b0, pre_gap: 1, exp_len: 11, exp_lat: 1771};
    vecs[2] = '{n_spam: 3, glitch: 1'b1, rand_rom: 1'b1, pre_gap: 6, exp_len: 11, exp_lat: 1771};
    vecs[3] = '{n_spam: 8, glitch: 1'b1, rand_rom: 1'b1, pre_gap: 0, exp_len: 11, exp_lat: 1771};
    t5_bits = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

    load_message();

    // Reset held for three cycles.
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_tx", 32'(tx0), 32'd1);
    check("reset_busy", 32'(busy0), 32'd0);
    check("reset_done", 32'(done0), 32'd0);
    check("reset_addr", 32'(addr0), 32'd0);
    check("reset_idx", 32'(idx0), 32'd0);
    check("reset_tx1", 32'(tx1), 32'd1);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Table of whole-message vectors, with random spam, ROM contents and gaps.
    for (int v = 0; v < 4; v++) begin
      if (vecs[v].rand_rom) begin
        for (int i = 0; i < 16; i++) rom[i] = 8'($urandom);
      end else begin
        load_message();
      end
      repeat (vecs[v].pre_gap + int'($urandom_range(0, 4))) @(negedge clk);
      send_msg(1'b0, vecs[v].exp_len, vecs[v].n_spam, vecs[v].glitch, 0,
               vecs[v].exp_lat, $sformatf("vec%0d", v));
    end
    load_message();

    // Reset pulse in the middle of data bit 3 of character 2.
    send_msg(1'b0, 11, 0, 1'b0, 2 * FRAME + 1 + 17 + 3 * CPB + 7, 1771, "abort");
    done_cnt = 0;
    repeat (200) begin
      @(negedge clk);
      if (done0 === 1'b1) done_cnt++;
    end
    check("abort_no_done_after", 32'(done_cnt), 32'd0);
    send_msg(1'b0, 11, 0, 1'b0, 0, 1771, "after_abort");

    // Single-character instance: exact bit sequence and latency.
    send_msg(1'b1, 1, 2, 1'b0, 0, 161, "len1");
    t5_bad = 0;
    for (int i = 0; i < 10; i++) if (cap[9 + CPB * i] !== t5_bits[i]) t5_bad++;
    check("len1_bits", 32'(t5_bad), 32'd0);
    sel = 1'b0;

    // start held high: back-to-back messages with one IDLE cycle between.
    gap = 0;
    seen_busy = 0;
    @(negedge clk);
    start0 = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 3600; k++) begin
      @(negedge clk);
      if (k == 1774) start0 = 1'b0;
      if (done0 === 1'b1) dk.push_back(k);
      if (dk.size() == 1 && k > dk[0] && seen_busy == 0) begin
        if (busy0 === 1'b1) seen_busy = 1;
        else gap++;
      end
    end
    check("held_done_count", 32'(dk.size()), 32'd2);
    check("held_first_done", 32'((dk.size() > 0) ? dk[0] - 1 : -1), 32'd1771);
    check("held_idle_gap", 32'(gap), 32'd1);
    check("held_period", 32'((dk.size() > 1) ? dk[1] - dk[0] : -1), 32'd1773);
    check("held_end_idle", 32'(busy0), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
